// File: rtl/idu_pkg.sv
// Purpose : shared opcodes, instruction classes and the decode helper for the
//           dual-issue dispatch unit.
// Latency : n/a (types and a pure combinational function only).
// Backpressure: n/a.
package idu_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_UNKNOWN
  } t_instr_class;

  typedef struct packed {
    t_instr_class cls;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         use_rs1;
    logic         use_rs2;
    logic         wr_rd;
  } t_dec;

  function automatic t_dec decode(input logic [31:0] instr);
    t_dec d;
    d.cls     = CLS_UNKNOWN;
    d.rs1     = instr[19:15];
    d.rs2     = instr[24:20];
    d.rd      = instr[11:7];
    d.use_rs1 = 1'b0;
    d.use_rs2 = 1'b0;
    d.wr_rd   = 1'b0;
    case (instr[6:0])
      OPC_OP_IMM: begin d.cls = CLS_ALU;    d.use_rs1 = 1'b1; d.wr_rd = 1'b1; end
      OPC_OP:     begin d.cls = CLS_ALU;    d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; d.wr_rd = 1'b1; end
      OPC_LUI:    begin d.cls = CLS_ALU;    d.wr_rd = 1'b1; end
      OPC_AUIPC:  begin d.cls = CLS_ALU;    d.wr_rd = 1'b1; end
      OPC_JAL:    begin d.cls = CLS_JUMP;   d.wr_rd = 1'b1; end
      OPC_JALR:   begin d.cls = CLS_JUMP;   d.use_rs1 = 1'b1; d.wr_rd = 1'b1; end
      OPC_BRANCH: begin d.cls = CLS_BRANCH; d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
      OPC_LOAD:   begin d.cls = CLS_LOAD;   d.use_rs1 = 1'b1; d.wr_rd = 1'b1; end
      OPC_STORE:  begin d.cls = CLS_STORE;  d.use_rs1 = 1'b1; d.use_rs2 = 1'b1; end
      default:    ;
    endcase
    // x0 is hardwired, so writing it never creates a dependency.
    d.wr_rd = d.wr_rd && (d.rd != 5'd0);
    return d;
  endfunction

endpackage

// File: rtl/idu_dual_issue_if.sv
// Purpose : fetch / issue / writeback / flush bundle of the dispatch unit.
// Latency : n/a (wires only). slave = dispatch unit, master = fetch+execute side.
// Backpressure: fetch_ready throttles fetch; issue_ready completes issue on the edge.
interface idu_dual_issue_if;
  logic [1:0]  fetch_valid;
  logic [31:0] fetch_instr0;
  logic [31:0] fetch_instr1;
  logic        fetch_ready;
  logic [1:0]  issue_valid;
  logic [31:0] issue_instr0;
  logic [31:0] issue_instr1;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;

  modport master (
    output fetch_valid, fetch_instr0, fetch_instr1, issue_ready, wb_valid, wb_rd, flush,
    input  fetch_ready, issue_valid, issue_instr0, issue_instr1
  );

  modport slave (
    input  fetch_valid, fetch_instr0, fetch_instr1, issue_ready, wb_valid, wb_rd, flush,
    output fetch_ready, issue_valid, issue_instr0, issue_instr1
  );
endinterface

// File: rtl/idu_scoreboard.sv
// Purpose : NUM_REGS busy bits (set at issue, cleared at writeback) with two hazard queries.
// Latency : set/clear visible next cycle; with IDU_SB_BYPASS_EN a clear also masks hazards same cycle.
// Backpressure: none. Ports: Clk/Rst, i_set{0,1}_*, i_clr_*, i_q{0,1}_* query fields, o_haz{0,1}.
module idu_scoreboard #(
  parameter int NUM_REGS = 32
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_set0_vld,
  input  logic [4:0] i_set0_rd,
  input  logic       i_set1_vld,
  input  logic [4:0] i_set1_rd,
  input  logic       i_clr_vld,
  input  logic [4:0] i_clr_rd,
  input  logic [4:0] i_q0_rs1,
  input  logic       i_q0_use_rs1,
  input  logic [4:0] i_q0_rs2,
  input  logic       i_q0_use_rs2,
  input  logic [4:0] i_q0_rd,
  input  logic       i_q0_wr_rd,
  input  logic [4:0] i_q1_rs1,
  input  logic       i_q1_use_rs1,
  input  logic [4:0] i_q1_rs2,
  input  logic       i_q1_use_rs2,
  input  logic [4:0] i_q1_rd,
  input  logic       i_q1_wr_rd,
  output logic       o_haz0,
  output logic       o_haz1
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_busy_q;

  function automatic logic [NUM_REGS-1:0] reg_mask(input logic vld, input logic [4:0] rd);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (vld && (rd != 5'd0) && (int'(rd) < NUM_REGS)) m[rd] = 1'b1;
    return m;
  endfunction

  function automatic logic is_busy(input logic [NUM_REGS-1:0] vec, input logic [4:0] r);
    return (int'(r) < NUM_REGS) ? vec[r] : 1'b0;
  endfunction

  assign w_set_mask = reg_mask(i_set0_vld, i_set0_rd) | reg_mask(i_set1_vld, i_set1_rd);
  assign w_clr_mask = reg_mask(i_clr_vld, i_clr_rd);

`ifdef IDU_SB_BYPASS_EN
  // A retiring register is already free for dependants this cycle.
  assign w_busy_q = r_busy & ~w_clr_mask;
`else
  assign w_busy_q = r_busy;
`endif

  assign o_haz0 = (i_q0_use_rs1 && is_busy(w_busy_q, i_q0_rs1)) ||
                  (i_q0_use_rs2 && is_busy(w_busy_q, i_q0_rs2)) ||
                  (i_q0_wr_rd   && is_busy(w_busy_q, i_q0_rd));
  assign o_haz1 = (i_q1_use_rs1 && is_busy(w_busy_q, i_q1_rs1)) ||
                  (i_q1_use_rs2 && is_busy(w_busy_q, i_q1_rs2)) ||
                  (i_q1_wr_rd   && is_busy(w_busy_q, i_q1_rd));

  // Set is applied after clear: a new producer wins over an old writeback.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_busy <= '0;
    else     r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
  end

endmodule

// File: rtl/idu_dual_issue.sv
// Purpose : dual-issue dispatch: Q_DEPTH-entry instruction queue + scoreboard, issues 0/1/2 per cycle.
// Latency : push at edge N issuable in cycle N+1; issue outputs combinational from head and scoreboard.
// Backpressure: fetch_ready when >=2 free entries (registered count); entries held until issue_ready.
// Ports: Clk, Rst (async active-high), bus (idu_dual_issue_if.slave). Option macro: IDU_SB_BYPASS_EN.
module idu_dual_issue
  import idu_pkg::*;
#(
  parameter int Q_DEPTH  = 8,
  parameter int NUM_REGS = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  idu_dual_issue_if.slave   bus
);

  localparam int PW = $clog2(Q_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(Q_DEPTH - 2);

  logic [31:0]   r_q [Q_DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic [PW-1:0] w_head1;
  logic [PW-1:0] w_tail1;
  t_dec          w_d0;
  t_dec          w_d1;
  logic          w_haz0;
  logic          w_haz1;
  logic          w_raw;
  logic          w_waw;
  logic          w_pair_ok;
  logic          w_v0;
  logic          w_v1;
  logic          w_push;
  logic [1:0]    w_npush;
  logic [1:0]    w_npop;
  logic          w_fetch_ready;

  assign w_head1 = r_head + PW'(1);
  assign w_tail1 = r_tail + PW'(1);
  assign w_d0    = decode(r_q[r_head]);
  assign w_d1    = decode(r_q[w_head1]);

  idu_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .Clk          (Clk),
    .Rst          (Rst),
    .i_set0_vld   (bus.issue_ready && w_v0 && w_d0.wr_rd),
    .i_set0_rd    (w_d0.rd),
    .i_set1_vld   (bus.issue_ready && w_v1 && w_d1.wr_rd),
    .i_set1_rd    (w_d1.rd),
    .i_clr_vld    (bus.wb_valid),
    .i_clr_rd     (bus.wb_rd),
    .i_q0_rs1     (w_d0.rs1),
    .i_q0_use_rs1 (w_d0.use_rs1),
    .i_q0_rs2     (w_d0.rs2),
    .i_q0_use_rs2 (w_d0.use_rs2),
    .i_q0_rd      (w_d0.rd),
    .i_q0_wr_rd   (w_d0.wr_rd),
    .i_q1_rs1     (w_d1.rs1),
    .i_q1_use_rs1 (w_d1.use_rs1),
    .i_q1_rs2     (w_d1.rs2),
    .i_q1_use_rs2 (w_d1.use_rs2),
    .i_q1_rd      (w_d1.rd),
    .i_q1_wr_rd   (w_d1.wr_rd),
    .o_haz0       (w_haz0),
    .o_haz1       (w_haz1)
  );

  // Intra-pair dependencies: the younger slot must not read or rewrite the older's rd.
  assign w_raw = w_d0.wr_rd &&
                 ((w_d1.use_rs1 && (w_d1.rs1 == w_d0.rd)) ||
                  (w_d1.use_rs2 && (w_d1.rs2 == w_d0.rd)));
  assign w_waw = w_d0.wr_rd && w_d1.wr_rd && (w_d1.rd == w_d0.rd);

  // Control flow at the head ends the group; unknown opcodes never pair; one memory port.
  assign w_pair_ok = (w_d0.cls inside {CLS_ALU, CLS_LOAD, CLS_STORE}) &&
                     (w_d1.cls != CLS_UNKNOWN) &&
                     !w_raw && !w_waw &&
                     !((w_d0.cls inside {CLS_LOAD, CLS_STORE}) &&
                       (w_d1.cls inside {CLS_LOAD, CLS_STORE}));

  assign w_v0 = !bus.flush && (r_count != '0) && !w_haz0;
  assign w_v1 = w_v0 && (r_count >= CW'(2)) && w_pair_ok && !w_haz1;

  assign bus.issue_valid  = {w_v1, w_v0};
  assign bus.issue_instr0 = w_v0 ? r_q[r_head]  : 32'd0;
  assign bus.issue_instr1 = w_v1 ? r_q[w_head1] : 32'd0;

  // Registered count only: a same-cycle pop does not open room for a push.
  assign w_fetch_ready   = (r_count <= READY_MAX);
  assign bus.fetch_ready = w_fetch_ready;

  assign w_push  = bus.fetch_valid[0] && w_fetch_ready && !bus.flush;
  assign w_npush = !w_push ? 2'd0 : (bus.fetch_valid[1] ? 2'd2 : 2'd1);
  assign w_npop  = !bus.issue_ready ? 2'd0 : (w_v1 ? 2'd2 : (w_v0 ? 2'd1 : 2'd0));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      r_tail  <= r_tail + PW'(w_npush);
      r_head  <= r_head + PW'(w_npop);
      r_count <= r_count + CW'(w_npush) - CW'(w_npop);
    end
  end

  // Storage needs no reset: every read is qualified by the count.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_q[r_tail] <= bus.fetch_instr0;
      if (bus.fetch_valid[1]) r_q[w_tail1] <= bus.fetch_instr1;
    end
  end

endmodule

// File: tb/tb_idu_dual_issue.sv
module tb_idu_dual_issue;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  idu_dual_issue_if bus();

  idu_dual_issue #(.Q_DEPTH(8), .NUM_REGS(32)) u_dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    bus.fetch_valid  = 2'b00;
    bus.fetch_instr0 = 32'd0;
    bus.fetch_instr1 = 32'd0;
    bus.issue_ready  = 1'b0;
    bus.wb_valid     = 1'b0;
    bus.wb_rd        = 5'd0;
    bus.flush        = 1'b0;
  endtask

  task automatic push2(input logic [31:0] a, input logic [31:0] b);
    bus.fetch_valid  = 2'b11;
    bus.fetch_instr0 = a;
    bus.fetch_instr1 = b;
    tick();
    bus.fetch_valid  = 2'b00;
  endtask

  task automatic wb(input logic [4:0] r);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = r;
    tick();
    bus.wb_valid = 1'b0;
    bus.wb_rd    = 5'd0;
  endtask

  // addi x0, x0, k : no rd written, distinct encodings for order checks
  function automatic logic [31:0] nop(input int k);
    return (32'(k) << 20) | 32'h0000_0013;
  endfunction

  task automatic test_reset();
    if (bus.issue_valid !== 2'b00) begin $display("FAIL rst_valid: got %b want 00", bus.issue_valid); n_err++; end
    n_vec++;
    if (bus.fetch_ready !== 1'b1) begin $display("FAIL rst_fready: got %b want 1", bus.fetch_ready); n_err++; end
    n_vec++;
    if (u_dut.u_sb.r_busy !== 32'h0) begin $display("FAIL rst_busy: got %h want 0", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.issue_ready = 1'b1;
    push2(32'h00200093, 32'h00300113);
    push2(32'h00400193, 32'h00500213);
    bus.issue_ready = 1'b0;
    settle();
    if (u_dut.u_sb.r_busy !== 32'h6) begin $display("FAIL midop_busy: got %h want 6", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
    #1 rst = 1'b1;
    #1;
    if (bus.issue_valid !== 2'b00) begin $display("FAIL async_rst_valid: got %b want 00", bus.issue_valid); n_err++; end
    n_vec++;
    if (bus.fetch_ready !== 1'b1) begin $display("FAIL async_rst_fready: got %b want 1", bus.fetch_ready); n_err++; end
    n_vec++;
    if (u_dut.u_sb.r_busy !== 32'h0) begin $display("FAIL async_rst_busy: got %h want 0", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
    if (bus.issue_instr0 !== 32'h0) begin $display("FAIL async_rst_instr0: got %h want 0", bus.issue_instr0); n_err++; end
    n_vec++;
    #1 rst = 1'b0;
    tick();
    settle();
    if (bus.issue_valid !== 2'b00) begin $display("FAIL post_rst_empty: got %b want 00", bus.issue_valid); n_err++; end
    n_vec++;
  endtask

  task automatic test_independent();
    bus.issue_ready = 1'b1;
    push2(32'h00200093, 32'h00300113);
    settle();
    if (bus.issue_valid !== 2'b11) begin $display("FAIL indep_valid: got %b want 11", bus.issue_valid); n_err++; end
    n_vec++;
    if (bus.issue_instr0 !== 32'h00200093) begin $display("FAIL indep_i0: got %h want 00200093", bus.issue_instr0); n_err++; end
    n_vec++;
    if (bus.issue_instr1 !== 32'h00300113) begin $display("FAIL indep_i1: got %h want 00300113", bus.issue_instr1); n_err++; end
    n_vec++;
    tick();
    settle();
    if (u_dut.u_sb.r_busy !== 32'h6) begin $display("FAIL indep_busy: got %h want 6", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
    if (bus.issue_valid !== 2'b00) begin $display("FAIL indep_drained: got %b want 00", bus.issue_valid); n_err++; end
    n_vec++;
    wb(5'd1);
    wb(5'd2);
    settle();
    if (u_dut.u_sb.r_busy !== 32'h0) begin $display("FAIL indep_wb_clear: got %h want 0", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
  endtask

  task automatic test_raw();
    bus.issue_ready = 1'b1;
    // addi x1,x0,2 ; addi x2,x1,1
    push2(32'h00200093, 32'h00108113);
    settle();
    if (bus.issue_valid !== 2'b01) begin $display("FAIL raw_valid: got %b want 01", bus.issue_valid); n_err++; end
    n_vec++;
    if (bus.issue_instr1 !== 32'h0) begin $display("FAIL raw_i1_zero: got %h want 0", bus.issue_instr1); n_err++; end
    n_vec++;
    tick();
    settle();
    if (bus.issue_valid !== 2'b00) begin $display("FAIL raw_sb_block: got %b want 00", bus.issue_valid); n_err++; end
    n_vec++;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    settle();
`ifdef IDU_SB_BYPASS_EN
    if (bus.issue_valid !== 2'b01) begin $display("FAIL raw_wb_cycle: got %b want 01", bus.issue_valid); n_err++; end
    n_vec++;
    if (bus.issue_instr0 !== 32'h00108113) begin $display("FAIL raw_wb_i0: got %h want 00108113", bus.issue_instr0); n_err++; end
    n_vec++;
    tick();
    bus.wb_valid = 1'b0;
    settle();
`else
    if (bus.issue_valid !== 2'b00) begin $display("FAIL raw_wb_cycle: got %b want 00", bus.issue_valid); n_err++; end
    n_vec++;
    tick();
    bus.wb_valid = 1'b0;
    settle();
    if (bus.issue_valid !== 2'b01) begin $display("FAIL raw_after_wb: got %b want 01", bus.issue_valid); n_err++; end
    n_vec++;
    if (bus.issue_instr0 !== 32'h00108113) begin $display("FAIL raw_after_i0: got %h want 00108113", bus.issue_instr0); n_err++; end
    n_vec++;
    tick();
    settle();
`endif
    if (bus.issue_valid !== 2'b00) begin $display("FAIL raw_done: got %b want 00", bus.issue_valid); n_err++; end
    n_vec++;
    if (u_dut.u_sb.r_busy !== 32'h4) begin $display("FAIL raw_busy: got %h want 4", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
    wb(5'd2);
  endtask

  task automatic test_branch();
    bus.issue_ready = 1'b1;
    push2(32'h00428063, 32'h00500113);
    settle();
    if (bus.issue_valid !== 2'b01) begin $display("FAIL br_alone: got %b want 01", bus.issue_valid); n_err++; end
    n_vec++;
    if (bus.issue_instr0 !== 32'h00428063) begin $display("FAIL br_i0: got %h want 00428063", bus.issue_instr0); n_err++; end
    n_vec++;
    tick();
    settle();
    if (bus.issue_instr0 !== 32'h00500113) begin $display("FAIL br_next_i0: got %h want 00500113", bus.issue_instr0); n_err++; end
    n_vec++;
    tick();
    settle();
    if (u_dut.u_sb.r_busy !== 32'h4) begin $display("FAIL br_busy: got %h want 4", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
    wb(5'd2);
  endtask

  task automatic test_mem();
    bus.issue_ready = 1'b1;
    push2(32'h00002083, 32'h00002103);
    settle();
    if (bus.issue_valid !== 2'b01) begin $display("FAIL mem_single0: got %b want 01", bus.issue_valid); n_err++; end
    n_vec++;
    tick();
    settle();
    if (bus.issue_valid !== 2'b01) begin $display("FAIL mem_single1: got %b want 01", bus.issue_valid); n_err++; end
    n_vec++;
    if (bus.issue_instr0 !== 32'h00002103) begin $display("FAIL mem_i0: got %h want 00002103", bus.issue_instr0); n_err++; end
    n_vec++;
    tick();
    settle();
    if (u_dut.u_sb.r_busy !== 32'h6) begin $display("FAIL mem_busy: got %h want 6", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
    wb(5'd1);
    wb(5'd2);
  endtask

  task automatic test_set_clear();
    bus.issue_ready  = 1'b1;
    bus.fetch_valid  = 2'b01;
    bus.fetch_instr0 = 32'h00200093;
    tick();
    bus.fetch_valid = 2'b00;
    bus.wb_valid    = 1'b1;
    bus.wb_rd       = 5'd1;
    tick();
    bus.wb_valid = 1'b0;
    settle();
    if (u_dut.u_sb.r_busy !== 32'h2) begin $display("FAIL set_beats_clr: got %h want 2", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
    wb(5'd1);
    settle();
    if (u_dut.u_sb.r_busy !== 32'h0) begin $display("FAIL set_clr_after: got %h want 0", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
  endtask

  task automatic test_full_wrap();
    bus.issue_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      push2(nop(2 * p + 1), nop(2 * p + 2));
      settle();
      if (bus.fetch_ready !== (p < 3)) begin $display("FAIL full_fready%0d: got %b want %b", p, bus.fetch_ready, (p < 3)); n_err++; end
      n_vec++;
    end
    // Full queue: same-cycle push is refused even though a pair pops.
    bus.fetch_valid  = 2'b11;
    bus.fetch_instr0 = nop(99);
    bus.fetch_instr1 = nop(100);
    bus.issue_ready  = 1'b1;
    settle();
    if (bus.issue_instr0 !== nop(1) || bus.issue_instr1 !== nop(2)) begin
      $display("FAIL full_head: got %h/%h want %h/%h", bus.issue_instr0, bus.issue_instr1, nop(1), nop(2)); n_err++;
    end
    n_vec++;
    tick();
    bus.fetch_valid = 2'b00;
    for (int p = 1; p < 4; p++) begin
      settle();
      if (bus.issue_valid !== 2'b11 || bus.issue_instr0 !== nop(2 * p + 1) || bus.issue_instr1 !== nop(2 * p + 2)) begin
        $display("FAIL wrap_order%0d: got %b %h/%h want 11 %h/%h", p, bus.issue_valid, bus.issue_instr0, bus.issue_instr1, nop(2 * p + 1), nop(2 * p + 2));
        n_err++;
      end
      n_vec++;
      tick();
    end
    settle();
    if (bus.issue_valid !== 2'b00) begin $display("FAIL full_drained: got %b want 00", bus.issue_valid); n_err++; end
    n_vec++;
  endtask

  task automatic test_flush();
    bus.issue_ready  = 1'b1;
    bus.fetch_valid  = 2'b01;
    bus.fetch_instr0 = 32'h00200093;
    tick();
    bus.fetch_valid = 2'b00;
    tick();
    bus.issue_ready = 1'b0;
    push2(nop(11), nop(12));
    bus.flush       = 1'b1;
    bus.fetch_valid = 2'b11;
    bus.fetch_instr0 = nop(13);
    bus.fetch_instr1 = nop(14);
    bus.issue_ready = 1'b1;
    settle();
    if (bus.issue_valid !== 2'b00) begin $display("FAIL flush_forced: got %b want 00", bus.issue_valid); n_err++; end
    n_vec++;
    tick();
    bus.flush       = 1'b0;
    bus.fetch_valid = 2'b00;
    settle();
    if (bus.issue_valid !== 2'b00) begin $display("FAIL flush_empty: got %b want 00", bus.issue_valid); n_err++; end
    n_vec++;
    if (bus.fetch_ready !== 1'b1) begin $display("FAIL flush_fready: got %b want 1", bus.fetch_ready); n_err++; end
    n_vec++;
    if (u_dut.u_sb.r_busy !== 32'h2) begin $display("FAIL flush_busy_kept: got %h want 2", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
    push2(nop(15), nop(16));
    settle();
    if (bus.issue_valid !== 2'b11 || bus.issue_instr0 !== nop(15)) begin
      $display("FAIL flush_refill: got %b %h want 11 %h", bus.issue_valid, bus.issue_instr0, nop(15)); n_err++;
    end
    n_vec++;
    tick();
    wb(5'd1);
    settle();
    if (u_dut.u_sb.r_busy !== 32'h0) begin $display("FAIL flush_wb_clear: got %h want 0", u_dut.u_sb.r_busy); n_err++; end
    n_vec++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #3;
    test_reset();
    test_independent();
    test_raw();
    test_branch();
    test_mem();
    test_set_clear();
    test_full_wrap();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
